uart_tx_buffer: RTL

Byte FIFO between the processor core's transmit strobe interface and the UART transmitter's AXI-stream input. The core writes bytes with a single-cycle strobe at any rate; the buffer holds them and presents them one at a time on a registered valid/ready stream, at the pace the UART accepts them. Overruns are dropped and flagged, never stalled, because the core's transmit path has no back-pressure.

---
 rtl/uart_tx_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
//
// Byte FIFO between the core's transmit strobe and the UART transmitter's
// AXI-stream input. The core pushes bytes with a one-cycle strobe and has no
// back-pressure. Writes that arrive while the buffer is full are dropped and
// recorded in a sticky overflow flag. Bytes leave one at a time on a
// registered valid/ready stream.
//
// Storage is a (DEPTH-1)-entry circular RAM followed by a single output
// register that drives m_tdata/m_tvalid. count covers both, so total capacity
// is DEPTH bytes.
//
// Ports
//   clk       single clock
//   n_rst     asynchronous active-low reset
//   wr_en     write strobe from the core, one byte per cycle high
//   wr_data   byte to enqueue, sampled when wr_en=1
//   clear     synchronous flush of all held bytes and the overflow flag
//   full      registered, count==DEPTH
//   empty     registered, count==0
//   count     registered, number of bytes held (0..DEPTH)
//   overflow  sticky, set when a write was dropped
//   m_tdata   byte offered to the UART
//   m_tvalid  m_tdata is valid
//   m_tready  UART accepts the byte
// ---------------------------------------------------------------------------
module uart_tx_buffer #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clear,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [7:0]    m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready
);

  // The RAM holds everything except the byte sitting in the output register.
  // DEPTH-1 is not a power of two, so pointers wrap explicitly at RAM_DEPTH-1
  // rather than relying on natural binary rollover.
  localparam int RAM_DEPTH = DEPTH - 1;
  localparam int PW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [PW-1:0] PTR_LAST  = PW'(RAM_DEPTH - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [7:0]    ram [RAM_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          pop;
  logic          push;
  logic          ram_empty;
  logic          to_out;
  logic          to_ram;
  logic          load_from_ram;
  logic [CW-1:0] ram_count;
  logic [CW-1:0] count_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake and routing decisions.
  // The RAM can only be non-empty while the output register is valid, so the
  // RAM occupancy is simply count minus the output register's valid bit.
  // A write is accepted when there is room, or when a pop frees a slot in the
  // same cycle. An accepted byte bypasses the RAM whenever the output register
  // is (or is about to become) vacant and nothing older is waiting in the RAM;
  // this keeps the one-cycle write latency and the no-bubble streaming.
  always_comb begin
    pop           = m_tvalid & m_tready;
    ram_count     = count - CW'(m_tvalid);
    ram_empty     = (ram_count == '0);
    push          = wr_en & ((count != COUNT_MAX) | pop);
    to_out        = push & (~m_tvalid | (pop & ram_empty));
    to_ram        = push & ~to_out;
    load_from_ram = pop & ~ram_empty;
    count_next    = count + CW'(push) - CW'(pop);
  end

  // RAM write port. No reset is needed on the array itself: pointers and count
  // define which entries are meaningful. When the buffer is full and a push
  // coincides with a pop, wr_ptr equals rd_ptr; the output register still
  // captures the old entry because both sides sample pre-edge contents.
  always_ff @(posedge clk) begin
    if (to_ram && !clear) begin
      ram[wr_ptr] <= wr_data;
    end
  end

  // Output register, pointers and status flags.
  // clear outranks any simultaneous write or pop, including suppressing the
  // overflow that a dropped write would otherwise record. Status flags are
  // derived from the next count so they line up with count itself.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_tdata  <= 8'h00;
      m_tvalid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else if (clear) begin
      m_tdata  <= 8'h00;
      m_tvalid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (load_from_ram) begin
        m_tdata  <= ram[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end else if (to_out) begin
        m_tdata  <= wr_data;
        m_tvalid <= 1'b1;
      end else if (pop) begin
        m_tvalid <= 1'b0;
      end

      if (to_ram) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end

      count <= count_next;
      full  <= (count_next == COUNT_MAX);
      empty <= (count_next == '0);

      if (wr_en && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
